serial_word_comparator: RTL and testbench
=========================================

# serial_word_comparator

Parametrised bit-serial magnitude comparator: compares two WIDTH-bit words presented one bit pair per accepted cycle and reports greater/equal/less. Generalises the fixed LSB-first unsigned serial comparator with word framing, run-time bit order (LSB- or MSB-first), signed/unsigned mode, input qualification with bubbles, and a done strobe. It sits behind serial links and shift-register front ends that need a framed compare result.

## Interface
- WIDTH, 8, word length in bits (>= 2)
- CW, $clog2(WIDTH), bit-counter width (derived, not overridden)
- clk  in  1  clock, rising edge
- resetBar  in  1  asynchronous, active-low reset
- start  in  1  begin new word; clears result, loads mode
- msbFirst  in  1  bit order for the word; sampled on start
- signedMode  in  1  two's-complement compare; sampled on start
- bitValid  in  1  a/b hold a valid bit pair this cycle
- a, b  in  1  serial operand bits
- gd, ed, ld  out  1 each  a>b, a==b, a<b; exactly one high at all times
- busy  out  1  word in progress
- done  out  1  one-cycle pulse: final result valid

## Operation
- States: IDLE, RUN. Reset -> IDLE, gd=0, ed=1, ld=0, busy=0, done=0, cnt=0.
- start (any state): -> RUN, cnt=0, result=EQ, latch msbFirst/signedMode, busy=1. bitValid on the start cycle is ignored. start in RUN aborts the current word; no done.
- RUN, bitValid=1: consume bit, cnt++; bitValid=0: hold everything (bubble).
- LSB-first: if a!=b, result = (a ? GT : LT), overriding earlier bits. On the final bit (cnt==WIDTH-1) with signedMode and a!=b, sense inverts: result = (a ? LT : GT).
- MSB-first: first differing bit decides; later bits ignored once result != EQ. If the deciding bit is bit 0 of the stream (sign) and signedMode, sense inverts.
- Final bit consumed: -> IDLE, busy=0, done=1 for one cycle; gd/ed/ld hold until next start or reset.
- IDLE, bitValid=1 without start: ignored, outputs unchanged.
- Intermediate gd/ed/ld during RUN are provisional (LSB-first) or final-once-decided (MSB-first); only done-qualified values are contractual.

## Timing
- All outputs registered; bit accepted on edge k updates gd/ed/ld visible after edge k.
- Latency: done and final result appear after the edge consuming the WIDTH-th valid bit; minimum word = 1 start cycle + WIDTH cycles.
- Back-to-back: start may be asserted in the done cycle; new word begins, done still pulses that cycle, result clears on the following edge.
- resetBar low mid-word: immediate return to reset values, no done.
- cnt wraps never; counter saturation at WIDTH-1 triggers the exit.

## Structure
- Package serial_cmp_pkg: state enum (IDLE, RUN), result enum (EQ, GT, LT) and the one-hot decode to gd/ed/ld.
- One sub-module: serial_bit_counter (CW-bit counter with clear, enable, last-bit flag), instantiated once.
- Compare/mode logic and FSM in the top module.

## Test plan
- WIDTH=4, LSB-first unsigned, 1010 vs 1110 (pairs 00,11,01,11) -> done after 4th bit, ld=1.
- WIDTH=4, MSB-first unsigned, 1111 vs 1110 -> gd=1 only after 4th bit; ed=1 for bits 1-3.
- WIDTH=8, MSB-first, 10011001 vs 01111111: unsigned -> gd=1; signed (-103 vs 127) -> ld=1, decided after first bit.
- WIDTH=8, LSB-first signed, 0x80 vs 0x01 with bitValid gaps of 0-3 cycles -> ld=1, done exactly once, busy high throughout.
- WIDTH=4, 1011 vs 1011 -> ed=1 at done; then start after 2 bits of next word, restart, no done for aborted word.
- resetBar low after 2 bits -> gd=0, ed=1, ld=0, busy=0 immediately; IDLE bits ignored afterward.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// -----------------------------------------------------------------------------
// serial_cmp_pkg
// Shared types and helpers for the bit-serial word comparator.
//   state_t   : controller states (IDLE, RUN)
//   result_t  : running compare result (EQ, GT, LT)
//   flags_t   : one-hot gd/ed/ld output bundle
//   decode_result() : result_t -> flags_t (exactly one flag high)
//   pick_result()   : result for a differing bit pair, optionally sign-inverted
// -----------------------------------------------------------------------------
package serial_cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        EQ = 2'd0,
        GT = 2'd1,
        LT = 2'd2
    } result_t;

    typedef struct packed {
        logic gd;
        logic ed;
        logic ld;
    } flags_t;

    function automatic flags_t decode_result(input result_t r);
        flags_t f;
        f = '{gd: 1'b0, ed: 1'b1, ld: 1'b0};
        case (r)
            GT:      f = '{gd: 1'b1, ed: 1'b0, ld: 1'b0};
            LT:      f = '{gd: 1'b0, ed: 1'b0, ld: 1'b1};
            default: f = '{gd: 1'b0, ed: 1'b1, ld: 1'b0};
        endcase
        return f;
    endfunction

    // For a differing pair, a=1 normally means a>b. On the two's-complement
    // sign bit the weight is negative, so a=1 means a<b instead.
    function automatic result_t pick_result(input logic a_bit, input logic invert);
        return (a_bit ^ invert) ? GT : LT;
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// -----------------------------------------------------------------------------
// serial_bit_counter
// Counts accepted bit pairs within a word. Returns to zero after the last bit
// so it never wraps past WIDTH-1.
//   clk, resetBar : clock, async active-low reset
//   i_clr         : synchronous clear (new word)
//   i_en          : a bit pair is consumed this cycle
//   o_cnt         : index of the bit pair currently presented
//   o_last        : current bit pair is the final one of the word
// -----------------------------------------------------------------------------
module serial_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          resetBar,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_last
);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            r_cnt <= '0;
        end else if (i_clr || (i_en && w_last)) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;

endmodule

// File: rtl/serial_word_comparator.sv
// -----------------------------------------------------------------------------
// serial_word_comparator
// Framed bit-serial magnitude comparator for two WIDTH-bit words, with
// run-time bit order and signed/unsigned mode latched at start.
//   clk, resetBar       : clock, async active-low reset
//   start               : begin (or restart) a word; clears result
//   msbFirst            : bit order of the word, sampled on start
//   signedMode          : two's-complement compare, sampled on start
//   bitValid, a, b      : qualified serial operand bit pair
//   gd, ed, ld          : a>b, a==b, a<b (one-hot, registered)
//   busy                : word in progress
//   done                : one-cycle pulse when the final result is valid
// -----------------------------------------------------------------------------
module serial_word_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic resetBar,
    input  logic start,
    input  logic msbFirst,
    input  logic signedMode,
    input  logic bitValid,
    input  logic a,
    input  logic b,
    output logic gd,
    output logic ed,
    output logic ld,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(WIDTH);

    state_t        r_state;
    state_t        w_state_nxt;
    result_t       r_result;
    result_t       w_result_nxt;
    logic          r_msb_first;
    logic          r_signed;
    logic          r_done;

    logic [CW-1:0] w_cnt;
    logic          w_last;
    logic          w_consume;
    logic          w_first;
    flags_t        w_flags;

    // start has priority: bitValid on the start cycle is not consumed.
    assign w_consume = (r_state == RUN) && bitValid && !start;
    assign w_first   = (w_cnt == '0);

    serial_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk      (clk),
        .resetBar (resetBar),
        .i_clr    (start),
        .i_en     (w_consume),
        .o_cnt    (w_cnt),
        .o_last   (w_last)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = RUN;
        end else if (w_consume && w_last) begin
            w_state_nxt = IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        w_flags = decode_result(r_result);
        gd      = w_flags.gd;
        ed      = w_flags.ed;
        ld      = w_flags.ld;
        busy    = (r_state == RUN);
        done    = r_done;
    end

    // Compare step. LSB-first: every differing bit overrides what came before,
    // and the last bit carries the sign. MSB-first: the first differing bit
    // wins, and only stream bit 0 carries the sign.
    always_comb begin
        w_result_nxt = r_result;
        if (a != b) begin
            if (r_msb_first) begin
                if (r_result == EQ) begin
                    w_result_nxt = pick_result(a, r_signed && w_first);
                end
            end else begin
                w_result_nxt = pick_result(a, r_signed && w_last);
            end
        end
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            r_result    <= EQ;
            r_msb_first <= 1'b0;
            r_signed    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_consume && w_last;
            if (start) begin
                r_result    <= EQ;
                r_msb_first <= msbFirst;
                r_signed    <= signedMode;
            end else if (w_consume) begin
                r_result <= w_result_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_comparator.sv
module tb_serial_word_comparator;

    logic clk = 1'b0;
    logic resetBar;
    logic start, msbFirst, signedMode, bitValid, a, b;
    logic gd4, ed4, ld4, busy4, done4;
    logic gd8, ed8, ld8, busy8, done8;

    int n_cmp = 0;
    int n_err = 0;
    int done4_total = 0;
    int done8_total = 0;
    int d_snap;

    logic [7:0] av, bv;

    always #5 clk = ~clk;

    serial_word_comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .resetBar(resetBar), .start(start), .msbFirst(msbFirst),
        .signedMode(signedMode), .bitValid(bitValid), .a(a), .b(b),
        .gd(gd4), .ed(ed4), .ld(ld4), .busy(busy4), .done(done4)
    );

    serial_word_comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .resetBar(resetBar), .start(start), .msbFirst(msbFirst),
        .signedMode(signedMode), .bitValid(bitValid), .a(a), .b(b),
        .gd(gd8), .ed(ed8), .ld(ld8), .busy(busy8), .done(done8)
    );

    always @(posedge clk) begin
        done4_total <= done4_total + int'(done4);
        done8_total <= done8_total + int'(done8);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs at the falling edge, then sample just after the rising edge.
    task automatic step(input logic s, input logic m, input logic sg,
                        input logic v, input logic ai, input logic bi);
        @(negedge clk);
        start = s; msbFirst = m; signedMode = sg; bitValid = v; a = ai; b = bi;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetBar = 1'b0;
        start = 0; msbFirst = 0; signedMode = 0; bitValid = 0; a = 0; b = 0;
        #1;
        chk("reset_flags4", {gd4, ed4, ld4}, 3'b010);
        chk("reset_busy4", busy4, 1'b0);
        chk("reset_done4", done4, 1'b0);
        chk("reset_flags8", {gd8, ed8, ld8}, 3'b010);
        chk("reset_busy8", busy8, 1'b0);
        @(negedge clk);
        resetBar = 1'b1;

        // 1: WIDTH=4 LSB-first unsigned, pairs 00,11,01,11 -> LT
        av = 8'b0000_1010; bv = 8'b0000_1110;
        step(1, 0, 0, 1, 1, 0);
        chk("t1_start_busy", busy4, 1'b1);
        chk("t1_start_flags", {gd4, ed4, ld4}, 3'b010);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, av[i], bv[i]);
            if (i < 3) chk("t1_no_early_done", done4, 1'b0);
        end
        chk("t1_done", done4, 1'b1);
        chk("t1_flags", {gd4, ed4, ld4}, 3'b001);
        chk("t1_busy_low", busy4, 1'b0);
        step(0, 0, 0, 0, 0, 0);
        chk("t1_done_pulse", done4, 1'b0);
        chk("t1_hold", {gd4, ed4, ld4}, 3'b001);

        // 2: WIDTH=4 MSB-first unsigned, 1111 vs 1110 -> GT only on last bit
        av = 8'b0000_1111; bv = 8'b0000_1110;
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, av[3-i], bv[3-i]);
            if (i < 3) chk("t2_eq_provisional", {gd4, ed4, ld4}, 3'b010);
        end
        chk("t2_done", done4, 1'b1);
        chk("t2_flags", {gd4, ed4, ld4}, 3'b100);

        // 3a: WIDTH=8 MSB-first unsigned, 10011001 vs 01111111 -> GT
        av = 8'b1001_1001; bv = 8'b0111_1111;
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, av[7], bv[7]);
        chk("t3u_first_bit", {gd8, ed8, ld8}, 3'b100);
        for (int i = 1; i < 8; i++) step(0, 0, 0, 1, av[7-i], bv[7-i]);
        chk("t3u_done", done8, 1'b1);
        chk("t3u_flags", {gd8, ed8, ld8}, 3'b100);

        // 3b: same words signed (-103 vs 127) -> LT decided on sign bit
        step(1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, av[7], bv[7]);
        chk("t3s_first_bit", {gd8, ed8, ld8}, 3'b001);
        for (int i = 1; i < 8; i++) step(0, 0, 0, 1, av[7-i], bv[7-i]);
        chk("t3s_done", done8, 1'b1);
        chk("t3s_flags", {gd8, ed8, ld8}, 3'b001);

        // 4: WIDTH=8 LSB-first signed, 0x80 vs 0x01 with 0-3 cycle bubbles -> LT
        av = 8'h80; bv = 8'h01;
        step(1, 0, 1, 0, 0, 0);
        d_snap = done8_total;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < (i % 4); g++) begin
                step(0, 0, 0, 0, 1, 0);
                chk("t4_busy_bubble", busy8, 1'b1);
            end
            step(0, 0, 0, 1, av[i], bv[i]);
            if (i < 7) chk("t4_busy_bit", busy8, 1'b1);
        end
        chk("t4_done", done8, 1'b1);
        chk("t4_flags", {gd8, ed8, ld8}, 3'b001);
        chk("t4_busy_low", busy8, 1'b0);
        step(0, 0, 0, 0, 0, 0);
        chk("t4_done_once", done8_total - d_snap, 32'd1);

        // 5: WIDTH=4 equal words, back-to-back start, then an aborted word
        av = 8'b0000_1011; bv = 8'b0000_1011;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, av[i], bv[i]);
        chk("t5_done", done4, 1'b1);
        chk("t5_flags", {gd4, ed4, ld4}, 3'b010);
        step(1, 0, 0, 1, 1, 0);
        d_snap = done4_total;
        chk("t5_b2b_done_clear", done4, 1'b0);
        chk("t5_b2b_busy", busy4, 1'b1);
        chk("t5_b2b_flags", {gd4, ed4, ld4}, 3'b010);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("t5_partial_gt", {gd4, ed4, ld4}, 3'b100);
        step(1, 0, 0, 0, 0, 0);
        chk("t5_abort_flags", {gd4, ed4, ld4}, 3'b010);
        chk("t5_abort_busy", busy4, 1'b1);
        chk("t5_abort_no_done", done4, 1'b0);
        av = 8'b0000_0001; bv = 8'b0000_0010;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, av[i], bv[i]);
        chk("t5_restart_flags", {gd4, ed4, ld4}, 3'b001);
        chk("t5_restart_done", done4, 1'b1);
        step(0, 0, 0, 0, 0, 0);
        chk("t5_single_done", done4_total - d_snap, 32'd1);

        // 6: reset mid-word, then unframed bits ignored in IDLE
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("t6_pre_reset", {gd4, ed4, ld4}, 3'b100);
        #2;
        resetBar = 1'b0;
        #1;
        chk("t6_rst_flags", {gd4, ed4, ld4}, 3'b010);
        chk("t6_rst_busy", busy4, 1'b0);
        chk("t6_rst_done", done4, 1'b0);
        chk("t6_rst_busy8", busy8, 1'b0);
        @(negedge clk);
        resetBar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1, 0);
            chk("t6_idle_flags", {gd4, ed4, ld4}, 3'b010);
            chk("t6_idle_busy", busy4, 1'b0);
            chk("t6_idle_done", done4, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
